svm_param_loader: RTL and testbench

SVM_PARAM_LOADER -- requirements
Module: svm_param_loader

---
 rtl/svm_pkg.sv | 19 +
 rtl/svm_row_packer.sv | 63 ++++++
 rtl/svm_param_loader.sv | 129 ++++++++++++
 tb/tb_svm_param_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared defaults and FSM state encoding for the SVM parameter loader
package svm_pkg;

  localparam int DEF_NBITS         = 9;
  localparam int DEF_VSUP_WIDTH    = 120;
  localparam int DEF_ASUP_WIDTH    = 155;
  localparam int DEF_F_WIDTH       = 214;
  localparam int DEF_LOG_SUP_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    INTERCEPT,
    FILL,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/svm_row_packer.sv
// rtl/svm_row_packer.sv - counts row words and scatters them into staged, then committed, row registers
module svm_row_packer import svm_pkg::*; #(
  parameter int NBITS      = DEF_NBITS,
  parameter int VSUP_WIDTH = DEF_VSUP_WIDTH,
  parameter int ASUP_WIDTH = DEF_ASUP_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBITS-1:0]              word,
  input  logic                          beat,
  input  logic                          clear,
  output logic [NBITS*VSUP_WIDTH-1:0]   v_support,
  output logic [NBITS*ASUP_WIDTH-1:0]   a_support,
  output logic [NBITS-1:0]              v_alpha,
  output logic [NBITS-1:0]              a_alpha,
  output logic                          row_full
);

  localparam int W    = VSUP_WIDTH + ASUP_WIDTH + 2;
  localparam int IDXW = $clog2(W);
  localparam logic [IDXW-1:0] V_ALPHA_IDX = IDXW'(W - 2);
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(W - 1);

  logic [IDXW-1:0]             idx;
  logic [NBITS*VSUP_WIDTH-1:0] v_stage;
  logic [NBITS*ASUP_WIDTH-1:0] a_stage;
  logic [NBITS-1:0]            v_alpha_stage;

  // High during the beat that completes the row; the outputs commit on that same edge.
  assign row_full = beat && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      v_stage       <= '0;
      a_stage       <= '0;
      v_alpha_stage <= '0;
      v_support     <= '0;
      a_support     <= '0;
      v_alpha       <= '0;
      a_alpha       <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (beat) begin
      idx <= row_full ? '0 : idx + 1'b1;
      for (int k = 0; k < VSUP_WIDTH; k++) begin
        if (idx == IDXW'(k)) v_stage[k*NBITS +: NBITS] <= word;
      end
      for (int k = 0; k < ASUP_WIDTH; k++) begin
        if (idx == IDXW'(VSUP_WIDTH + k)) a_stage[k*NBITS +: NBITS] <= word;
      end
      if (idx == V_ALPHA_IDX) v_alpha_stage <= word;
      // The final word bypasses staging so the whole row is visible in the write cycle.
      if (row_full) begin
        v_support <= v_stage;
        a_support <= a_stage;
        v_alpha   <= v_alpha_stage;
        a_alpha   <= word;
      end
    end
  end

endmodule

// File: rtl/svm_param_loader.sv
// rtl/svm_param_loader.sv - streams SVM support vectors, alphas and intercepts into the SVM row memory
module svm_param_loader import svm_pkg::*; #(
  parameter int NBITS         = DEF_NBITS,
  parameter int VSUP_WIDTH    = DEF_VSUP_WIDTH,
  parameter int ASUP_WIDTH    = DEF_ASUP_WIDTH,
  parameter int F_WIDTH       = DEF_F_WIDTH,
  parameter int LOG_SUP_WIDTH = DEF_LOG_SUP_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    load_done,
  input  logic signed [2*NBITS+LOG_SUP_WIDTH-1:0] v_intercept_in,
  input  logic signed [2*NBITS+LOG_SUP_WIDTH-1:0] a_intercept_in,
  input  logic signed [NBITS-1:0]                 s_word,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic                                    mem_write_ready,
  output logic [NBITS*VSUP_WIDTH-1:0]             v_in_support,
  output logic [NBITS*ASUP_WIDTH-1:0]             a_in_support,
  output logic [NBITS-1:0]                        v_in_alpha,
  output logic [NBITS-1:0]                        a_in_alpha,
  output logic signed [2*NBITS+LOG_SUP_WIDTH-1:0] v_in_intercept,
  output logic signed [2*NBITS+LOG_SUP_WIDTH-1:0] a_in_intercept,
  output logic                                    intercept_valid,
  output logic [7:0]                              mem_write_addr,
  output logic                                    mem_we,
  output logic                                    mem_write_done
);

  localparam logic [7:0] LAST_ROW = 8'(F_WIDTH - 1);

  state_t     state;
  logic [7:0] row;
  logic       beat;
  logic       clear;
  logic       row_full;

  assign beat  = s_valid && s_ready;
  assign clear = (state == IDLE) && start;

  svm_row_packer #(
    .NBITS      (NBITS),
    .VSUP_WIDTH (VSUP_WIDTH),
    .ASUP_WIDTH (ASUP_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .word      (s_word),
    .beat      (beat),
    .clear     (clear),
    .v_support (v_in_support),
    .a_support (a_in_support),
    .v_alpha   (v_in_alpha),
    .a_alpha   (a_in_alpha),
    .row_full  (row_full)
  );

  // Every output is registered and set on the edge entering the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      busy            <= 1'b0;
      s_ready         <= 1'b0;
      intercept_valid <= 1'b0;
      mem_we          <= 1'b1;
      mem_write_done  <= 1'b0;
      load_done       <= 1'b0;
      mem_write_addr  <= '0;
      v_in_intercept  <= '0;
      a_in_intercept  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            v_in_intercept <= v_intercept_in;
            a_in_intercept <= a_intercept_in;
            row            <= '0;
            busy           <= 1'b1;
            state          <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (mem_write_ready) begin
            intercept_valid <= 1'b1;
            state           <= INTERCEPT;
          end
        end
        INTERCEPT: begin
          intercept_valid <= 1'b0;
          s_ready         <= 1'b1;
          state           <= FILL;
        end
        FILL: begin
          if (row_full) begin
            s_ready        <= 1'b0;
            mem_we         <= 1'b0;
            mem_write_addr <= row;
            state          <= WRITE;
          end
        end
        WRITE: begin
          mem_we <= 1'b1;
          if (row == LAST_ROW) begin
            mem_write_done <= 1'b1;
            load_done      <= 1'b1;
            state          <= DONE;
          end else begin
            row     <= row + 8'd1;
            s_ready <= 1'b1;
            state   <= FILL;
          end
        end
        DONE: begin
          mem_write_done <= 1'b0;
          load_done      <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svm_param_loader.sv
// tb/tb_svm_param_loader.sv - randomized scoreboard bench for svm_param_loader
module tb_svm_param_loader;

  localparam int N  = 9;
  localparam int V  = 2;
  localparam int A  = 3;
  localparam int F  = 4;
  localparam int L  = 8;
  localparam int IW = 2*N + L;
  localparam int W  = V + A + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 load_done;
  logic signed [IW-1:0] v_int;
  logic signed [IW-1:0] a_int;
  logic signed [N-1:0]  s_word;
  logic                 s_valid;
  logic                 s_ready;
  logic                 mem_write_ready;
  logic [N*V-1:0]       v_in_support;
  logic [N*A-1:0]       a_in_support;
  logic [N-1:0]         v_in_alpha;
  logic [N-1:0]         a_in_alpha;
  logic signed [IW-1:0] v_in_intercept;
  logic signed [IW-1:0] a_in_intercept;
  logic                 intercept_valid;
  logic [7:0]           mem_write_addr;
  logic                 mem_we;
  logic                 mem_write_done;

  svm_param_loader #(
    .NBITS(N), .VSUP_WIDTH(V), .ASUP_WIDTH(A), .F_WIDTH(F), .LOG_SUP_WIDTH(L)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .load_done(load_done),
    .v_intercept_in(v_int), .a_intercept_in(a_int),
    .s_word(s_word), .s_valid(s_valid), .s_ready(s_ready),
    .mem_write_ready(mem_write_ready),
    .v_in_support(v_in_support), .a_in_support(a_in_support),
    .v_in_alpha(v_in_alpha), .a_in_alpha(a_in_alpha),
    .v_in_intercept(v_in_intercept), .a_in_intercept(a_in_intercept),
    .intercept_valid(intercept_valid), .mem_write_addr(mem_write_addr),
    .mem_we(mem_we), .mem_write_done(mem_write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]     addr;
    logic [N*V-1:0] vs;
    logic [N*A-1:0] as;
    logic [N-1:0]   va;
    logic [N-1:0]   aa;
  } wr_t;

  wr_t                 exp_wr[$];
  logic [2*IW-1:0]     exp_int[$];
  logic signed [N-1:0] src[$];
  wr_t                 last_row;
  wr_t                 mon_e;
  logic [2*IW-1:0]     mon_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_base = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int exp_period = 0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write, intercept and completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we == 1'b0) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", mem_write_addr, mon_e.addr);
          chk("wr_v_support", v_in_support, mon_e.vs);
          chk("wr_a_support", a_in_support, mon_e.as);
          chk("wr_v_alpha", v_in_alpha, mon_e.va);
          chk("wr_a_alpha", a_in_alpha, mon_e.aa);
          chk("wr_s_ready_low", s_ready, 1'b0);
          if (exp_period != 0 && wr_cnt != 0) chk("row_period", cyc - last_wr_cyc, exp_period);
          last_wr_cyc = cyc;
          wr_cnt++;
        end
      end
      if (intercept_valid) begin
        if (exp_int.size() == 0) begin
          chk("unexpected_intercept", 64'd1, 64'd0);
        end else begin
          mon_i = exp_int.pop_front();
          chk("v_intercept", {v_in_intercept}, mon_i[2*IW-1:IW]);
          chk("a_intercept", {a_in_intercept}, mon_i[IW-1:0]);
        end
      end
      if (mem_write_done || load_done) begin
        chk("done_pair", load_done, mem_write_done);
        done_cnt++;
      end
    end
  end

  task automatic begin_load(input logic signed [IW-1:0] vi, input logic signed [IW-1:0] ai,
                            input bit fixed0, input int rdy_delay, input int period);
    wr_t e;
    logic signed [N-1:0] wd;
    exp_period = period;
    wr_cnt     = 0;
    done_base  = done_cnt;
    for (int r = 0; r < F; r++) begin
      e.addr = 8'(r);
      for (int w = 0; w < W; w++) begin
        wd = (fixed0 && r == 0) ? N'(w + 1) : N'($urandom);
        src.push_back(wd);
        if (w < V)            e.vs[w*N +: N] = wd;
        else if (w < V + A)   e.as[(w-V)*N +: N] = wd;
        else if (w == V + A)  e.va = wd;
        else                  e.aa = wd;
      end
      exp_wr.push_back(e);
    end
    last_row = e;
    exp_int.push_back({vi, ai});
    @(negedge clk);
    start = 1'b1; v_int = vi; a_int = ai;
    mem_write_ready = (rdy_delay == 0);
    @(negedge clk);
    start = 1'b0; v_int = IW'($urandom); a_int = IW'($urandom);
    if (rdy_delay > 0) begin
      for (int i = 0; i < rdy_delay; i++) begin
        chk("wait_iv_low", intercept_valid, 1'b0);
        chk("wait_s_ready_low", s_ready, 1'b0);
        chk("wait_mem_we_high", mem_we, 1'b1);
        chk("wait_busy", busy, 1'b1);
        @(negedge clk);
      end
      mem_write_ready = 1'b1;
      @(negedge clk);
      chk("iv_after_ready", intercept_valid, 1'b1);
    end
  endtask

  // mode 0: always valid; mode 1: a gap before every word while ready; mode 2: random gaps.
  task automatic drive_stream(input int mode, input bit spam);
    bit pending = 1'b0;
    bit tog = 1'b1;
    int budget = 0;
    while (1) begin
      @(negedge clk);
      if (abort) begin s_valid = 1'b0; start = 1'b0; break; end
      if (pending) void'(src.pop_front());
      if (src.size() == 0) begin s_valid = 1'b0; start = 1'b0; break; end
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin if (s_ready) tog = !tog; s_valid = s_ready && tog; end
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_word = src[0];
      if (spam) begin
        start = ($urandom_range(0, 2) == 0);
        v_int = IW'($urandom); a_int = IW'($urandom);
      end
      mem_write_ready = 1'($urandom_range(0, 1));
      pending = s_valid && s_ready;
      budget++;
      if (budget > 2000) begin
        chk("stream_budget", 64'd1, 64'd0);
        s_valid = 1'b0; start = 1'b0;
        break;
      end
    end
  endtask

  task automatic finish_load(input logic signed [IW-1:0] vi, input logic signed [IW-1:0] ai);
    for (int i = 0; i < 200 && done_cnt == done_base; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - done_base, 1);
    chk("write_count", wr_cnt, F);
    chk("writes_left", exp_wr.size(), 0);
    chk("intercepts_left", exp_int.size(), 0);
    chk("busy_idle", busy, 1'b0);
    chk("hold_v_support", v_in_support, last_row.vs);
    chk("hold_a_support", a_in_support, last_row.as);
    chk("hold_v_alpha", v_in_alpha, last_row.va);
    chk("hold_a_alpha", a_in_alpha, last_row.aa);
    chk("hold_v_intercept", {v_in_intercept}, {vi});
    chk("hold_a_intercept", {a_in_intercept}, {ai});
    chk("hold_mem_we", mem_we, 1'b1);
  endtask

  logic signed [IW-1:0] rv, ra;

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_word = '0;
    v_int = '0; a_int = '0; mem_write_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b1);
    chk("rst_iv", intercept_valid, 1'b0);
    chk("rst_done", {mem_write_done, load_done}, 2'b00);
    chk("rst_addr", mem_write_addr, 8'd0);
    chk("rst_support", {v_in_support, a_in_support}, '0);
    chk("rst_alpha", {v_in_alpha, a_in_alpha}, '0);
    chk("rst_intercept", {v_in_intercept, a_in_intercept}, '0);
    rst = 1'b0;

    // Continuous stream, fixed first row 1..7, intercepts 100/-50.
    begin_load(100, -50, 1'b1, 0, W + 1);
    drive_stream(0, 1'b0);
    finish_load(100, -50);

    // Memory not ready for 10 cycles after start.
    rv = IW'($urandom); ra = IW'($urandom);
    begin_load(rv, ra, 1'b0, 10, W + 1);
    drive_stream(0, 1'b0);
    finish_load(rv, ra);

    // Gap before every word gives a 2*W+1 row period.
    rv = IW'($urandom); ra = IW'($urandom);
    begin_load(rv, ra, 1'b1, 0, 2*W + 1);
    drive_stream(1, 1'b0);
    finish_load(rv, ra);

    // Random gaps.
    for (int n = 0; n < 2; n++) begin
      rv = IW'($urandom); ra = IW'($urandom);
      begin_load(rv, ra, 1'b0, $urandom_range(0, 3), 0);
      drive_stream(2, 1'b0);
      finish_load(rv, ra);
    end

    // Start pulses and intercept changes while busy must be ignored.
    rv = IW'($urandom); ra = IW'($urandom);
    begin_load(rv, ra, 1'b0, 0, W + 1);
    drive_stream(0, 1'b1);
    finish_load(rv, ra);

    // Reset during the fill of row 2.
    rv = IW'($urandom); ra = IW'($urandom);
    begin_load(rv, ra, 1'b0, 0, 2*W + 1);
    fork
      drive_stream(1, 1'b0);
      begin
        for (int i = 0; i < 400 && wr_cnt < 2; i++) @(negedge clk);
        chk("rows_before_reset", wr_cnt, 2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_we", mem_we, 1'b1);
        chk("abort_s_ready", s_ready, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_next_mem_we", mem_we, 1'b1);
        chk("abort_next_busy", busy, 1'b0);
      end
    join
    src.delete();
    exp_wr.delete();
    chk("abort_intercepts_left", exp_int.size(), 0);
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;

    rv = IW'($urandom); ra = IW'($urandom);
    begin_load(rv, ra, 1'b1, 0, W + 1);
    drive_stream(0, 1'b0);
    finish_load(rv, ra);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
